// File: rtl/sclk_gen_prog_if.sv
// Control/status bundle of the programmable serial-clock generator.
interface sclk_gen_prog_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_half;
    logic             div_load;
    logic             sclk;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             lrclk;
    logic             frame_start;
    logic             busy;

    modport master (
        output en, div_half, div_load,
        input  sclk, sclk_rise, sclk_fall, lrclk, frame_start, busy
    );

    modport slave (
        input  en, div_half, div_load,
        output sclk, sclk_rise, sclk_fall, lrclk, frame_start, busy
    );
endinterface

// File: rtl/sclk_gen_prog.sv
// Programmable serial-clock generator with clk-domain edge strobes.
// Define FRAME_SYNC_EN to build the lrclk / frame_start word-select logic.
module sclk_gen_prog #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = 55,
    parameter int unsigned FRAME_BITS  = 32
) (
    input  logic           clk,
    input  logic           reset,
    sclk_gen_prog_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    if (FRAME_BITS < 2 || FRAME_BITS > 256) begin : g_bad_frame_bits
        $error("sclk_gen_prog: FRAME_BITS must be in 2..256");
    end

    logic [CNT_W-1:0] cuenta_q, cuenta_d;
    logic [CNT_W-1:0] div_reg_q, div_reg_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             sclk_q, sclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    logic running_c;
    logic term_c;
    logic rise_tog_c;
    logic fall_tog_c;
    logic boundary_c;

    // A high phase always runs to completion, so sclk==1 keeps the block running.
    always_comb begin
        running_c  = bus.en | sclk_q;
        term_c     = running_c & (cuenta_q == div_reg_q);
        rise_tog_c = term_c & ~sclk_q;
        fall_tog_c = term_c & sclk_q;
        boundary_c = fall_tog_c | ~running_c;
    end

    // Half-period counter, sclk and its edge strobes.
    always_comb begin
        cuenta_d = cuenta_q;
        sclk_d   = sclk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        busy_d   = running_c;
        if (!running_c) begin
            cuenta_d = '0;
            sclk_d   = 1'b0;
        end else if (term_c) begin
            cuenta_d = '0;
            sclk_d   = ~sclk_q;
            rise_d   = rise_tog_c;
            fall_d   = fall_tog_c;
        end else begin
            cuenta_d = cuenta_q + CNT_W'(1);
        end
    end

    // Divisor changes only at a period boundary so every period is whole.
    always_comb begin
        div_reg_d  = div_reg_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        if (bus.div_load) begin
            div_pend_d = bus.div_half;
            if (boundary_c) begin
                div_reg_d = bus.div_half;
                pend_d    = 1'b0;
            end else begin
                pend_d    = 1'b1;
            end
        end else if (boundary_c && pend_q) begin
            div_reg_d = div_pend_q;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta_q   <= '0;
            div_reg_q  <= DIV_RST;
            div_pend_q <= DIV_RST;
            pend_q     <= 1'b0;
            sclk_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cuenta_q   <= cuenta_d;
            div_reg_q  <= div_reg_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            sclk_q     <= sclk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.sclk_rise = rise_q;
    assign bus.sclk_fall = fall_q;
    assign bus.busy      = busy_q;

`ifdef FRAME_SYNC_EN
    localparam int unsigned BIT_W = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
    logic             lrclk_q, lrclk_d;
    logic             fstart_q, fstart_d;

    // Word select flips every FRAME_BITS falls; idle re-aligns the frame.
    always_comb begin
        bitcnt_d = bitcnt_q;
        lrclk_d  = lrclk_q;
        fstart_d = 1'b0;
        if (!running_c) begin
            bitcnt_d = '0;
            lrclk_d  = 1'b0;
        end else if (fall_tog_c) begin
            if (bitcnt_q == BIT_LAST) begin
                bitcnt_d = '0;
                lrclk_d  = ~lrclk_q;
                fstart_d = lrclk_q;
            end else begin
                bitcnt_d = bitcnt_q + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt_q <= '0;
            lrclk_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            lrclk_q  <= lrclk_d;
            fstart_q <= fstart_d;
        end
    end

    assign bus.lrclk       = lrclk_q;
    assign bus.frame_start = fstart_q;
`else
    assign bus.lrclk       = 1'b0;
    assign bus.frame_start = 1'b0;
`endif

endmodule

// File: doc/sclk_gen_prog.md
Name: sclk_gen_prog

Overview:
Programmable serial-clock generator for the audio codec path. It is the parametrised successor of the fixed 893 kHz divider.
- Divides clk by a runtime-loadable half-period count.
- Provides single-cycle edge strobes in the clk domain so downstream shifters need no edge detection.
- Optionally derives the word-select (lrclk) and frame-start signals from sclk.
- Feeds the DAC/ADC serialisers.

Parameters:
CNT_W, 8, width of the half-period counter and divisor.
DIV_DEFAULT, 55, half-period count loaded at reset; sclk half-period = DIV_DEFAULT+1 clk cycles (100 MHz -> 893 kHz).
FRAME_BITS, 32, sclk periods per lrclk half (bits per channel slot); legal range 2..256.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset.
en  in  1  run request; high = generate sclk.
div_half  in  CNT_W  new half-period count; half-period = div_half+1 clk cycles.
div_load  in  1  one-cycle strobe; captures div_half.
sclk  out  1  serial clock, registered.
sclk_rise  out  1  high for the first clk cycle in which sclk==1.
sclk_fall  out  1  high for the first clk cycle in which sclk==0 after a high phase.
lrclk  out  1  word select, changes only coincident with sclk_fall.
frame_start  out  1  one-cycle pulse coincident with the sclk_fall on which lrclk goes 1->0.
busy  out  1  en | sclk; low only when fully idle.

Behaviour:
- Reset (reset==0, async): cuenta=0, div_reg=DIV_DEFAULT, pend=0, sclk=0, sclk_rise=0, sclk_fall=0, bitcnt=0, lrclk=0, frame_start=0.
- Terminal condition: cuenta==div_reg while running.
  - At terminal: cuenta<=0 and sclk toggles.
  - Otherwise: cuenta<=cuenta+1, wrapping at CNT_W bits.
  - div_half=0 gives sclk=clk/2.
- Running state: en==1, or sclk==1.
  - With en==0 and sclk==1, counting continues until the falling toggle. The block then idles: cuenta held at 0, sclk=0.
  - No truncated high pulse is ever produced.
- Idle -> run: on the first cycle with en==1, counting starts from cuenta=0. The first rising toggle occurs div_reg+1 cycles later.
- Strobes: sclk_rise and sclk_fall are registered in the same cycle sclk changes. Both are 0 in every other cycle and never high together.
- Divisor update:
  - div_load latches div_half into div_pend and sets pend.
  - div_reg<=div_pend only at a falling toggle or while idle, so every period is whole.
  - div_load coincident with a falling toggle loads div_half into div_reg directly (bypass) and leaves pend=0.
  - Several loads before a boundary: the last one wins.
- Frame logic:
  - bitcnt increments on each sclk falling toggle.
  - At bitcnt==FRAME_BITS-1 with a falling toggle: bitcnt<=0 and lrclk toggles.
  - frame_start pulses when that toggle takes lrclk to 0.
  - On entering idle: bitcnt=0 and lrclk=0, so a restart is frame-aligned.
- Reset mid-operation: all state clears immediately, with no strobes emitted.
- Outputs are glitch-free register outputs; no combinational path from inputs to outputs.

Optional Feature:
Macro FRAME_SYNC_EN.
- Defined: bitcnt, lrclk and frame_start logic are built as described above.
- Undefined: that logic is removed; lrclk and frame_start are tied to 0. sclk, the strobes, busy and divisor behaviour are unchanged.

Test Plan:
1. Reset release with en=1, default divisor -> first sclk_rise at cycle 56 after en; sclk period 112 clk cycles; rise/fall strobes exactly one cycle each, 56 cycles apart.
2. Runtime divisor change: div_half=3 with div_load pulsed mid-high-phase -> current period completes at 56/56. Following period is 4 high / 4 low.
3. div_load with div_half=9 on the exact falling-toggle cycle -> the very next low phase is 10 cycles (bypass). A second load of 5 two cycles later takes effect only at the following fall.
4. en dropped while sclk==1 -> sclk stays high until its half-period ends, one sclk_fall, then sclk=0. busy goes 0 the cycle after; no further strobes.
5. FRAME_SYNC_EN, FRAME_BITS=4, div_half=1 -> lrclk toggles every 4 sclk periods (16 clk). frame_start pulses once per 32 clk, coincident with sclk_fall and lrclk 1->0.
6. Async reset asserted mid-high-phase with cuenta=20 -> sclk, strobes and lrclk go 0 immediately without a clk edge. After release, div_reg is back at 55 and the first rise is at cycle 56.
